// File: rtl/ws_keyscan_if.sv
`timescale 1ns/1ps
// Keyboard-pin and core-side bundle for ws_keyscan: column drive, row sense,
// keycode handshake and status flags.
interface ws_keyscan_if #(
  parameter int NCOLS = 11,
  parameter int NROWS = 4,
  parameter int KW    = $clog2(NCOLS * NROWS)
);
  logic             scan_en_in;
  logic [NCOLS-1:0] col_oe_o;
  logic [NROWS-1:0] rows_in;
  logic [KW-1:0]    key_code_o;
  logic             key_valid_o;
  logic             key_ready_in;
  logic             key_down_o;
  logic             overflow_o;
  logic             ovf_clr_in;

  modport slave (
    input  scan_en_in, rows_in, key_ready_in, ovf_clr_in,
    output col_oe_o, key_code_o, key_valid_o, key_down_o, overflow_o
  );

  modport master (
    output scan_en_in, rows_in, key_ready_in, ovf_clr_in,
    input  col_oe_o, key_code_o, key_valid_o, key_down_o, overflow_o
  );
endinterface

// File: rtl/ws_keyscan.sv
`timescale 1ns/1ps
// Generic NCOLS x NROWS key-matrix scanner: open-drain column walk, whole-scan
// debounce with single-key lockout, and a keycode FIFO with valid/ready.
module ws_keyscan #(
  parameter int NCOLS          = 11,
  parameter int NROWS          = 4,
  parameter int SETTLE_CYC     = 16,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  ws_keyscan_if.slave bus
);
  localparam int NKEYS = NCOLS * NROWS;
  localparam int KW    = $clog2(NKEYS);
  localparam int CW    = $clog2(NCOLS);
  localparam int SW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_EVAL   = 2'd3
  } state_t;

  state_t           r_state, w_state_nx;
  logic [CW-1:0]    r_col, w_col_nx;
  logic [SW-1:0]    r_settle, w_settle_nx;
  logic [NCOLS-1:0] r_col_oe, w_col_oe_nx;
  logic [NKEYS-1:0] r_image;
  logic [1:0]       w_nset;
  logic [KW-1:0]    w_code;
  logic             r_cand_key, w_cand_key_nx;
  logic [KW-1:0]    r_cand, w_cand_nx;
  logic [3:0]       r_count, w_count_nx, w_count_inc;
  logic             r_key_down, w_down_nx, w_push;
  logic [KW-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_rd, r_wr, w_rd_nx, w_wr_nx;
  logic [AW:0]      r_fill, w_fill_nx;
  logic             w_pop, w_full, w_wr_en, w_drop;
  logic [KW-1:0]    w_head_nx, r_key_code;
  logic             r_key_valid, r_ovf;

  // Scan sequencer; the column enable is registered from the next state.
  always_comb begin
    w_state_nx  = r_state;
    w_col_nx    = r_col;
    w_settle_nx = r_settle;
    case (r_state)
      ST_IDLE: begin
        if (bus.scan_en_in) begin
          w_state_nx  = ST_DRIVE;
          w_col_nx    = {CW{1'b0}};
          w_settle_nx = {SW{1'b0}};
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (r_settle == SW'(SETTLE_CYC - 1)) begin
          w_state_nx = ST_SAMPLE;
        end else begin
          w_settle_nx = r_settle + SW'(1);
        end
      end
      ST_SAMPLE: begin
        if (r_col == CW'(NCOLS - 1)) begin
          w_state_nx = ST_EVAL;
        end else begin
          w_state_nx  = ST_DRIVE;
          w_col_nx    = r_col + CW'(1);
          w_settle_nx = {SW{1'b0}};
        end
      end
      ST_EVAL: begin
        w_col_nx    = {CW{1'b0}};
        w_settle_nx = {SW{1'b0}};
        if (bus.scan_en_in) begin
          w_state_nx = ST_DRIVE;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    if (w_state_nx == ST_DRIVE || w_state_nx == ST_SAMPLE) begin
      w_col_oe_nx = NCOLS'(1) << w_col_nx;
    end else begin
      w_col_oe_nx = {NCOLS{1'b0}};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= ST_IDLE;
      r_col    <= {CW{1'b0}};
      r_settle <= {SW{1'b0}};
      r_col_oe <= {NCOLS{1'b0}};
      r_image  <= {NKEYS{1'b0}};
    end else begin
      r_state  <= w_state_nx;
      r_col    <= w_col_nx;
      r_settle <= w_settle_nx;
      r_col_oe <= w_col_oe_nx;
      if (r_state == ST_SAMPLE) begin
        for (int c = 0; c < NCOLS; c++) begin
          if (CW'(c) == r_col) r_image[c*NROWS +: NROWS] <= ~bus.rows_in;
        end
      end
    end
  end

  // Scan image classification: 0, 1 or 2+ closed keys, and the code of one of them.
  always_comb begin
    w_nset = 2'd0;
    w_code = {KW{1'b0}};
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (r_image[i]) begin
        w_code = KW'(i);
        if (w_nset != 2'd2) w_nset = w_nset + 2'd1;
      end
    end
  end

  always_comb begin
    w_cand_key_nx = r_cand_key;
    w_cand_nx     = r_cand;
    w_count_nx    = r_count;
    w_down_nx     = r_key_down;
    w_push        = 1'b0;
    w_count_inc   = (r_count >= DB_MAX) ? DB_MAX : r_count + 4'd1;
    if (r_state == ST_EVAL) begin
      case (w_nset)
        2'd0: begin
          w_cand_key_nx = 1'b0;
          w_count_nx    = r_cand_key ? 4'd1 : w_count_inc;
          if (w_count_nx == DB_MAX) w_down_nx = 1'b0;
          else                      w_down_nx = r_key_down;
        end
        2'd1: begin
          w_cand_key_nx = 1'b1;
          w_cand_nx     = w_code;
          w_count_nx    = (r_cand_key && r_cand == w_code) ? w_count_inc : 4'd1;
          if (w_count_nx == DB_MAX && !r_key_down) begin
            w_down_nx = 1'b1;
            w_push    = 1'b1;
          end else begin
            w_down_nx = r_key_down;
          end
        end
        default: begin
          w_cand_key_nx = 1'b0;
          w_cand_nx     = {KW{1'b0}};
          w_count_nx    = 4'd0;
        end
      endcase
    end else begin
      w_push = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cand_key <= 1'b0;
      r_cand     <= {KW{1'b0}};
      r_count    <= 4'd0;
      r_key_down <= 1'b0;
    end else begin
      r_cand_key <= w_cand_key_nx;
      r_cand     <= w_cand_nx;
      r_count    <= w_count_nx;
      r_key_down <= w_down_nx;
    end
  end

  // FIFO bookkeeping; the next head is precomputed so the outputs stay registered.
  always_comb begin
    w_pop   = r_key_valid & bus.key_ready_in;
    w_full  = (r_fill == (AW+1)'(FIFO_DEPTH));
    w_wr_en = w_push & (~w_full | w_pop);
    w_drop  = w_push & w_full & ~w_pop;
    w_rd_nx = w_pop ? r_rd + AW'(1) : r_rd;
    w_wr_nx = w_wr_en ? r_wr + AW'(1) : r_wr;
    case ({w_wr_en, w_pop})
      2'b10:   w_fill_nx = r_fill + (AW+1)'(1);
      2'b01:   w_fill_nx = r_fill - (AW+1)'(1);
      default: w_fill_nx = r_fill;
    endcase
    w_head_nx = (w_wr_en && (w_rd_nx == r_wr)) ? w_code : r_mem[w_rd_nx];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= {KW{1'b0}};
      r_rd        <= {AW{1'b0}};
      r_wr        <= {AW{1'b0}};
      r_fill      <= {(AW+1){1'b0}};
      r_key_code  <= {KW{1'b0}};
      r_key_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_wr_en) r_mem[r_wr] <= w_code;
      r_rd        <= w_rd_nx;
      r_wr        <= w_wr_nx;
      r_fill      <= w_fill_nx;
      r_key_valid <= (w_fill_nx != {(AW+1){1'b0}});
      if (w_fill_nx != {(AW+1){1'b0}}) r_key_code <= w_head_nx;
      if (w_drop)               r_ovf <= 1'b1;
      else if (bus.ovf_clr_in)  r_ovf <= 1'b0;
    end
  end

  assign bus.col_oe_o    = r_col_oe;
  assign bus.key_code_o  = r_key_code;
  assign bus.key_valid_o = r_key_valid;
  assign bus.key_down_o  = r_key_down;
  assign bus.overflow_o  = r_ovf;
endmodule

// File: tb/tb_ws_keyscan.sv
`timescale 1ns/1ps
// Self-checking bench for ws_keyscan: scan-level vector table, hand-written
// corner sequences, and randomized key activity against a window-based model.
module tb_ws_keyscan;
  localparam int NC = 11, NR = 4, NK = NC * NR, KW = 6;
  localparam int SC = 16, DB = 4, DEPTH = 4;
  localparam int PER = NC * (SC + 1) + 1;
  localparam logic [NK-1:0] NONE = '0;

  typedef struct {
    bit            rst;
    int            rep;
    logic [NK-1:0] keys;
    bit            rdy;
    bit            down;
    bit            valid;
    logic [KW-1:0] code;
    bit            ovf;
  } vec_t;

  logic          clk, rst_n;
  logic [NK-1:0] keys;
  logic [NR-1:0] rows_v;
  int            n_pass = 0, n_total = 0;
  vec_t          vecs[$];

  ws_keyscan_if #(.NCOLS(NC), .NROWS(NR)) bus();

  ws_keyscan #(.NCOLS(NC), .NROWS(NR), .SETTLE_CYC(SC), .DEBOUNCE_SCANS(DB),
               .FIFO_DEPTH(DEPTH)) dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive matrix: a closed key pulls its row low while its column is driven.
  always_comb begin
    rows_v = {NR{1'b1}};
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++)
        if (bus.col_oe_o[c] && keys[c*NR+r]) rows_v[r] = 1'b0;
  end
  assign bus.rows_in = rows_v;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [NK-1:0] kb(int c);
    logic [NK-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  function automatic int classify(logic [NK-1:0] k);
    if ($countones(k) == 0) return -1;
    if ($countones(k) > 1) return -2;
    for (int i = 0; i < NK; i++) if (k[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic add(bit rst, int rep, logic [NK-1:0] k, bit rdy, bit down, bit valid,
                     int code, bit ovf);
    vec_t v;
    v.rst = rst; v.rep = rep; v.keys = k; v.rdy = rdy;
    v.down = down; v.valid = valid; v.code = KW'(code); v.ovf = ovf;
    vecs.push_back(v);
  endtask

  // Leaves the bench at the negedge of the first DRIVE cycle of column 0.
  task automatic do_reset();
    rst_n = 1'b0;
    keys = NONE;
    bus.key_ready_in = 1'b0;
    bus.ovf_clr_in = 1'b0;
    bus.scan_en_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.col_oe", bus.col_oe_o, 0);
    chk("rst.code", bus.key_code_o, 0);
    chk("rst.valid", bus.key_valid_o, 0);
    chk("rst.down", bus.key_down_o, 0);
    chk("rst.ovf", bus.overflow_o, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full scan period; returns just after the EVAL result has registered.
  task automatic scan(input logic [NK-1:0] k, input bit r);
    keys = k;
    bus.key_ready_in = r;
    repeat (PER) @(posedge clk);
    @(negedge clk);
    bus.key_ready_in = 1'b0;
  endtask

  task automatic press_release(input int code, input int clr_scan);
    for (int s = 0; s < DB; s++) begin
      bus.ovf_clr_in = (clr_scan == s);
      scan(kb(code), 1'b0);
      bus.ovf_clr_in = 1'b0;
    end
  endtask

  int hist[$];
  int q[$];
  bit m_down, m_ovf;
  int m_last;

  initial begin
    int exp_codes[6];
    logic [NK-1:0] k;
    bit rdy, all_eq;
    int v;

    rst_n = 1'b1;
    keys = NONE;
    bus.scan_en_in = 1'b1;
    bus.key_ready_in = 1'b0;
    bus.ovf_clr_in = 1'b0;
    #3;

    // Idle column walk: one-hot 0..10, 17 cycles each, then one EVAL cycle.
    do_reset();
    for (int s = 0; s < 10; s++) begin
      for (int t = 0; t < PER; t++) begin
        chk($sformatf("walk.s%0d.t%0d", s, t), bus.col_oe_o,
            (t < PER - 1) ? (64'd1 << (t / (SC + 1))) : 64'd0);
        @(posedge clk);
        @(negedge clk);
      end
      chk("walk.valid", bus.key_valid_o, 0);
      chk("walk.down", bus.key_down_o, 0);
    end

    // Scan-level table: single press, bounce, rollover.
    add(1, 3, kb(14), 0, 0, 0, 0, 0);
    add(0, 1, kb(14), 0, 1, 1, 14, 0);
    add(0, 1, kb(14), 1, 1, 0, 14, 0);
    add(0, 3, NONE,   0, 1, 0, 14, 0);
    add(0, 1, NONE,   0, 0, 0, 14, 0);
    add(1, 2, kb(37), 0, 0, 0, 0, 0);
    add(0, 1, NONE,   0, 0, 0, 0, 0);
    add(0, 3, kb(37), 0, 0, 0, 0, 0);
    add(0, 1, kb(37), 0, 1, 1, 37, 0);
    add(0, 3, NONE,   0, 1, 1, 37, 0);
    add(0, 1, NONE,   0, 0, 1, 37, 0);
    add(1, 3, kb(0),  0, 0, 0, 0, 0);
    add(0, 1, kb(0),  0, 1, 1, 0, 0);
    add(0, 6, kb(0) | kb(21), 0, 1, 1, 0, 0);
    add(0, 4, kb(21), 0, 1, 1, 0, 0);
    add(0, 1, NONE,   1, 1, 0, 0, 0);
    add(0, 2, NONE,   0, 1, 0, 0, 0);
    add(0, 1, NONE,   0, 0, 0, 0, 0);
    add(0, 3, kb(21), 0, 0, 0, 0, 0);
    add(0, 1, kb(21), 0, 1, 1, 21, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      for (int j = 0; j < vecs[i].rep; j++) begin
        scan(vecs[i].keys, vecs[i].rdy);
        chk($sformatf("vec%0d.%0d.down", i, j), bus.key_down_o, vecs[i].down);
        chk($sformatf("vec%0d.%0d.valid", i, j), bus.key_valid_o, vecs[i].valid);
        chk($sformatf("vec%0d.%0d.code", i, j), bus.key_code_o, vecs[i].code);
        chk($sformatf("vec%0d.%0d.ovf", i, j), bus.overflow_o, vecs[i].ovf);
      end
    end

    // FIFO fill and overflow; the 6th drop coincides with a held clear.
    exp_codes = '{3, 10, 22, 30, 43, 5};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      press_release(exp_codes[i], (i == 5) ? DB - 1 : -1);
      chk($sformatf("fifo.p%0d.down", i), bus.key_down_o, 1);
      chk($sformatf("fifo.p%0d.head", i), bus.key_code_o, 3);
      chk($sformatf("fifo.p%0d.ovf", i), bus.overflow_o, (i >= 4) ? 1 : 0);
      for (int s = 0; s < DB; s++) begin
        bus.ovf_clr_in = (i == 4 && s == 0);
        scan(NONE, 1'b0);
        bus.ovf_clr_in = 1'b0;
        if (i == 4 && s == 0) chk("fifo.clr", bus.overflow_o, 0);
      end
      chk($sformatf("fifo.r%0d.down", i), bus.key_down_o, 0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("fifo.pop%0d.valid", i), bus.key_valid_o, 1);
      chk($sformatf("fifo.pop%0d.code", i), bus.key_code_o, exp_codes[i]);
      bus.key_ready_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.key_ready_in = 1'b0;
    end
    chk("fifo.empty.valid", bus.key_valid_o, 0);
    chk("fifo.empty.hold", bus.key_code_o, 30);
    chk("fifo.ovf.sticky", bus.overflow_o, 1);
    bus.ovf_clr_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ovf_clr_in = 1'b0;
    chk("fifo.ovf.clr", bus.overflow_o, 0);

    // Asynchronous reset in the middle of column 7's drive phase.
    do_reset();
    press_release(3, -1);
    for (int s = 0; s < DB; s++) scan(NONE, 1'b0);
    press_release(10, -1);
    chk("arst.pre.valid", bus.key_valid_o, 1);
    chk("arst.pre.code", bus.key_code_o, 3);
    chk("arst.pre.down", bus.key_down_o, 1);
    repeat (7 * (SC + 1) + 5) @(posedge clk);
    #2;
    chk("arst.pre.col", bus.col_oe_o, 64'h080);
    rst_n = 1'b0;
    #1;
    chk("arst.col", bus.col_oe_o, 0);
    chk("arst.valid", bus.key_valid_o, 0);
    chk("arst.down", bus.key_down_o, 0);
    do_reset();
    chk("arst.restart.col0", bus.col_oe_o, 1);
    repeat (SC + 1) @(posedge clk);
    @(negedge clk);
    chk("arst.restart.col1", bus.col_oe_o, 2);

    // Randomized key activity against a sliding-window reference model.
    do_reset();
    hist.delete();
    q.delete();
    m_down = 1'b0;
    m_ovf = 1'b0;
    m_last = 0;
    k = NONE;
    for (int n = 0; n < 60; n++) begin
      if (n == 0 || $urandom_range(2) == 0) begin
        case ($urandom_range(5))
          0, 1:    k = NONE;
          2, 3, 4: k = kb(int'($urandom_range(NK - 1)));
          default: k = kb(int'($urandom_range(NK - 1))) | kb(int'($urandom_range(NK - 1)));
        endcase
      end
      rdy = ($urandom_range(3) == 0);
      scan(k, rdy);
      if (rdy) begin
        if (q.size() > 0) m_last = q[$];
        q.delete();
      end
      v = classify(k);
      hist.push_back(v);
      if (hist.size() > DB) void'(hist.pop_front());
      if (hist.size() == DB) begin
        all_eq = 1'b1;
        foreach (hist[j]) if (hist[j] != v) all_eq = 1'b0;
        if (all_eq && v >= 0 && !m_down) begin
          m_down = 1'b1;
          if (q.size() < DEPTH) q.push_back(v);
          else m_ovf = 1'b1;
        end else if (all_eq && v == -1) begin
          m_down = 1'b0;
        end
      end
      if (q.size() > 0) m_last = q[0];
      chk($sformatf("rnd%0d.down", n), bus.key_down_o, m_down);
      chk($sformatf("rnd%0d.valid", n), bus.key_valid_o, (q.size() > 0) ? 1 : 0);
      chk($sformatf("rnd%0d.code", n), bus.key_code_o, m_last);
      chk($sformatf("rnd%0d.ovf", n), bus.overflow_o, m_ovf);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
